uart_tx: RTL and testbench

- Serial UART transmitter. Accepts a parallel word with a valid strobe and shifts it out on a single line at one bit per clock.
- Frame order: start bit, data LSB first, optional parity bit, stop bit.
- The bit-rate clock is generated upstream; clk is the bit clock.
- Top-level leaf of the TX path; Busy_UART is the upstream back-pressure signal.

---
 rtl/uart_tx_pkg.sv | 21 ++
 rtl/uart_tx_parity_calc.sv | 18 +
 rtl/uart_tx.sv | 145 ++++++++++++++
 tb/tb_uart_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART transmitter.
//   state_t   - transmitter FSM states
//   LINE_IDLE / START_BIT / STOP_BIT - serial line levels
//   PAR_EVEN / PAR_ODD               - parity type encodings
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: combinational parity generator.
//   data     [Data_Width-1:0] in  - data word
//   par_type                  in  - PAR_EVEN / PAR_ODD
//   parity                    out - parity bit to transmit
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int Data_Width = 8
) (
  input  logic [Data_Width-1:0] data,
  input  logic                  par_type,
  output logic                  parity
);

  // Even parity is the plain XOR; odd parity inverts it.
  assign parity = (^data) ^ (par_type == PAR_ODD);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, one bit per clk.
// Frame: start bit, data LSB first, optional parity bit, stop bit(s).
//   clk             in  - bit clock, rising edge
//   RST             in  - synchronous active-high reset
//   P_Data_UART     in  - parallel data word
//   Data_Valid_UART in  - request strobe
//   Par_En_UART     in  - 1 = insert parity bit
//   Par_Type_UART   in  - 0 = even, 1 = odd parity
//   TX_Out_UART     out - serial line, idle high
//   Busy_UART       out - high while a frame is in flight
// Build option: define UART_TX_TWO_STOP_EN for two stop bits.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int Data_Width = 8
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [Data_Width-1:0] P_Data_UART,
  input  logic                  Data_Valid_UART,
  input  logic                  Par_En_UART,
  input  logic                  Par_Type_UART,
  output logic                  TX_Out_UART,
  output logic                  Busy_UART
);

  localparam int CNT_W = (Data_Width > 1) ? $clog2(Data_Width) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(Data_Width - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [Data_Width-1:0] data_q, data_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_d, busy_d;
  logic                  load;
  logic                  par_calc;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop_phase_q, stop_phase_d;
`endif

  // Parity is taken from the word being captured and held with it, so
  // later input changes cannot disturb the frame in flight.
  uart_tx_parity_calc #(
    .Data_Width(Data_Width)
  ) u_parity (
    .data     (P_Data_UART),
    .par_type (Par_Type_UART),
    .parity   (par_calc)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      par_bit_q   <= 1'b0;
      par_en_q    <= 1'b0;
      TX_Out_UART <= LINE_IDLE;
      Busy_UART   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      par_bit_q   <= par_bit_d;
      par_en_q    <= par_en_d;
      TX_Out_UART <= tx_d;
      Busy_UART   <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop_phase_q <= stop_phase_d;
`endif
    end
  end

  // Line outputs are decoded from the current state and registered, so
  // the line shows the state entered one edge earlier.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    tx_d      = LINE_IDLE;
    busy_d    = 1'b1;
    load      = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop_phase_d = stop_phase_q;
`endif

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        tx_d   = LINE_IDLE;
        load   = Data_Valid_UART;
      end
      START: begin
        tx_d    = START_BIT;
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        tx_d = data_q[cnt_q];
        if (cnt_q == LAST_BIT) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        tx_d    = par_bit_q;
        state_d = STOP;
      end
      STOP: begin
        tx_d = STOP_BIT;
`ifdef UART_TX_TWO_STOP_EN
        if (!stop_phase_q) begin
          stop_phase_d = 1'b1;
        end else begin
          stop_phase_d = 1'b0;
          if (Data_Valid_UART) load = 1'b1;
          else                 state_d = IDLE;
        end
`else
        if (Data_Valid_UART) load = 1'b1;
        else                 state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (load) begin
      state_d   = START;
      data_d    = P_Data_UART;
      par_bit_d = par_calc;
      par_en_d  = Par_En_UART;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int N_STOP = 2;
`else
  localparam int N_STOP = 1;
`endif

  logic         clk;
  logic         RST;
  logic [W-1:0] P_Data_UART;
  logic         Data_Valid_UART;
  logic         Par_En_UART;
  logic         Par_Type_UART;
  logic         TX_Out_UART;
  logic         Busy_UART;

  int pass_cnt = 0;
  int total_cnt = 0;

  uart_tx #(.Data_Width(W)) dut (
    .clk             (clk),
    .RST             (RST),
    .P_Data_UART     (P_Data_UART),
    .Data_Valid_UART (Data_Valid_UART),
    .Par_En_UART     (Par_En_UART),
    .Par_Type_UART   (Par_Type_UART),
    .TX_Out_UART     (TX_Out_UART),
    .Busy_UART       (Busy_UART)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a queue of line levels still owed by the current frame.
  // cur_* is the symbol of the state the DUT is in now; it appears on the
  // line after the next edge.
  bit q[$];
  bit cur_bit = 1'b1;
  bit cur_busy = 1'b0;
  bit exp_tx = 1'b1;
  bit exp_busy = 1'b0;
  bit mvalid = 1'b0;

  always @(posedge clk) begin
    if (RST) begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      q.delete();
      cur_bit  = 1'b1;
      cur_busy = 1'b0;
      mvalid   = 1'b1;
    end else begin
      exp_tx   = cur_bit;
      exp_busy = cur_busy;
      if (q.size() != 0) begin
        cur_bit = q.pop_front();
      end else if (Data_Valid_UART) begin
        q.push_back(1'b0);
        for (int i = 0; i < W; i++) q.push_back(P_Data_UART[i]);
        if (Par_En_UART) q.push_back((^P_Data_UART) ^ Par_Type_UART);
        for (int s = 0; s < N_STOP; s++) q.push_back(1'b1);
        cur_bit  = q.pop_front();
        cur_busy = 1'b1;
      end else begin
        cur_bit  = 1'b1;
        cur_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("model_tx", {31'd0, TX_Out_UART}, {31'd0, exp_tx});
      check("model_busy", {31'd0, Busy_UART}, {31'd0, exp_busy});
    end
  end

  // Sends one frame from idle and checks it against hand-computed values.
  task automatic lit_frame(input logic [7:0] d, input logic pen, input logic ptype,
                           input logic exp_par, input string nm);
    logic [15:0] line;
    logic [7:0]  got;
    int          busy_n;
    P_Data_UART     = d;
    Par_En_UART     = pen;
    Par_Type_UART   = ptype;
    Data_Valid_UART = 1'b1;
    @(posedge clk); #1;
    Data_Valid_UART = 1'b0;
    P_Data_UART     = ~d;
    Par_En_UART     = ~pen;
    Par_Type_UART   = ~ptype;
    busy_n = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      line[i] = TX_Out_UART;
      if (Busy_UART) busy_n++;
    end
    for (int i = 0; i < 8; i++) got[i] = line[i+1];
    check({nm, "_start"}, {31'd0, line[0]}, 32'd0);
    check({nm, "_data"}, {24'd0, got}, {24'd0, d});
    if (pen) check({nm, "_parity"}, {31'd0, line[9]}, {31'd0, exp_par});
    check({nm, "_stop"}, {31'd0, line[9 + int'(pen)]}, 32'd1);
    check({nm, "_idle_after"}, {31'd0, line[9 + int'(pen) + N_STOP]}, 32'd1);
    check({nm, "_busy_len"}, busy_n, 10 + int'(pen) + N_STOP - 1);
  endtask

  initial begin
    int low_n;
    RST = 1'b1;
    Data_Valid_UART = 1'b0;
    P_Data_UART = '0;
    Par_En_UART = 1'b0;
    Par_Type_UART = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_tx", {31'd0, TX_Out_UART}, 32'd1);
    check("reset_busy", {31'd0, Busy_UART}, 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_tx", {31'd0, TX_Out_UART}, 32'd1);
    end

    lit_frame(8'hAA, 1'b0, 1'b0, 1'b0, "aa_nopar");
    lit_frame(8'hAA, 1'b1, 1'b0, 1'b0, "aa_even");
    lit_frame(8'hAA, 1'b1, 1'b1, 1'b1, "aa_odd");
    lit_frame(8'h01, 1'b1, 1'b0, 1'b1, "01_even");

    // Back-to-back: valid held high, data churning every cycle.
    Data_Valid_UART = 1'b1;
    Par_En_UART = 1'b1;
    @(posedge clk); #1;
    low_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!Busy_UART) low_n++;
      P_Data_UART = W'($urandom);
      Par_Type_UART = 1'($urandom);
    end
    check("b2b_busy_never_low", low_n, 0);
    Data_Valid_UART = 1'b0;
    repeat (16) @(posedge clk);
    #1;

    // Reset in the middle of the data bits.
    P_Data_UART = 8'h00;
    Par_En_UART = 1'b0;
    Data_Valid_UART = 1'b1;
    @(posedge clk); #1;
    Data_Valid_UART = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    RST = 1'b1;
    @(posedge clk); #1;
    check("midreset_tx", {31'd0, TX_Out_UART}, 32'd1);
    check("midreset_busy", {31'd0, Busy_UART}, 32'd0);
    RST = 1'b0;
    @(posedge clk); #1;
    lit_frame(8'h5A, 1'b1, 1'b1, 1'b1, "5a_odd_after_rst");

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      RST             = ($urandom_range(0, 99) == 0);
      Data_Valid_UART = ($urandom_range(0, 3) != 0);
      P_Data_UART     = W'($urandom);
      Par_En_UART     = 1'($urandom);
      Par_Type_UART   = 1'($urandom);
    end
    RST = 1'b0;
    Data_Valid_UART = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
